// File: rtl/spi_dac_frame_receiver_if.sv
// Carries the 3-wire DAC serial lines and the receiver's decoded frame results.
// The transmitter or bench holds the master modport. The receiver holds the slave modport.
interface spi_dac_frame_receiver_if #(
  parameter int SAMPLE_BITS = 12
);
  logic                   input_SPI_SCLK;
  logic                   input_SPI_SYNC_n;
  logic                   input_SPI_DIN;
  logic [SAMPLE_BITS-1:0] outputSample;
  logic [1:0]             outputPowerDown;
  logic                   sampleValid;
  logic                   frameError;
  logic                   isBusy;
  logic [15:0]            framesReceived;
  logic [7:0]             errorCount;

  modport master (
    output input_SPI_SCLK, input_SPI_SYNC_n, input_SPI_DIN,
    input  outputSample, outputPowerDown, sampleValid, frameError, isBusy,
           framesReceived, errorCount
  );

  modport slave (
    input  input_SPI_SCLK, input_SPI_SYNC_n, input_SPI_DIN,
    output outputSample, outputPowerDown, sampleValid, frameError, isBusy,
           framesReceived, errorCount
  );
endinterface

// File: rtl/spi_dac_frame_receiver.sv
// Oversampling slave receiver for the SCLK/SYNC_n/DIN DAC protocol.
// It deserializes 16-bit frames and counts good frames and aborted frames.
module spi_dac_frame_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int SAMPLE_BITS = 12
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset_n,
  spi_dac_frame_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

  // All three lines pass through the same synchronizer depth, so they stay aligned with each other.
  logic [1:0] sclk_sync, sync_n_sync, din_sync;
  logic       sclk_prev;
  logic       sclk, sync_n, din, fall, bit_event;

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [4:0]              bit_count, count_next;
  logic                    load, valid_next, error_next;
  logic [SAMPLE_BITS-1:0]  sample_q;
  logic [1:0]              power_down_q;
  logic                    valid_q, error_q;
  logic [15:0]             frames_q;
  logic [7:0]              errors_q;
  logic                    unused_msb;

  assign sclk      = sclk_sync[1];
  assign sync_n    = sync_n_sync[1];
  assign din       = din_sync[1];
  assign fall      = !sclk && sclk_prev;
  assign bit_event = fall && !sync_n;
  // The oldest don't-care bit shifts out of the register and is never read.
  assign unused_msb = shift_reg[FRAME_BITS-1];

  // Reset to 1 models idle-high lines, so leaving reset does not create a false SCLK fall.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync   <= '1;
      sync_n_sync <= '1;
      din_sync    <= '1;
      sclk_prev   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of its neighbour,
      // which is what makes this a shift chain and not a single flop.
      sclk_sync   <= {sclk_sync[0], bus.input_SPI_SCLK};
      sync_n_sync <= {sync_n_sync[0], bus.input_SPI_SYNC_n};
      din_sync    <= {din_sync[0], bus.input_SPI_DIN};
      sclk_prev   <= sclk;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default here, so no path can leave a value
    // unassigned and infer a latch.
    state_next = state;
    shift_next = shift_reg;
    count_next = bit_count;
    load       = 1'b0;
    valid_next = 1'b0;
    error_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (!sync_n) begin
          state_next = SHIFT;
          count_next = '0;
          if (bit_event) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], din};
            count_next = 5'd1;
          end
        end
      end
      SHIFT: begin
        if (sync_n) begin
          state_next = IDLE;
          error_next = (bit_count != '0);
        end else if (bit_event) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], din};
          count_next = bit_count + 5'd1;
          if (bit_count == 5'(FRAME_BITS - 1)) begin
            state_next = WAIT_END;
            load       = 1'b1;
            valid_next = 1'b1;
          end
        end
      end
      WAIT_END: begin
        if (sync_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_count    <= '0;
      sample_q     <= '0;
      power_down_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      frames_q     <= '0;
      errors_q     <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_count <= count_next;
      valid_q   <= valid_next;
      error_q   <= error_next;
      if (load) begin
        sample_q     <= shift_next[SAMPLE_BITS-1:0];
        power_down_q <= shift_next[SAMPLE_BITS+1:SAMPLE_BITS];
        frames_q     <= frames_q + 16'd1;
      end
      if (error_next && errors_q != 8'hFF) errors_q <= errors_q + 8'd1;
    end
  end

  assign bus.outputSample    = sample_q;
  assign bus.outputPowerDown = power_down_q;
  assign bus.sampleValid     = valid_q;
  assign bus.frameError      = error_q;
  assign bus.isBusy          = (state != IDLE);
  assign bus.framesReceived  = frames_q;
  assign bus.errorCount      = errors_q;

endmodule
